// File: rtl/frame_seq_pkg.sv
// -----------------------------------------------------------------------------
// frame_seq_pkg
// Shared definitions for the per-frame update sequencer of the pong display:
// sequencer state encoding, VGA 640x480@60 Hz line constants, default
// sequencing parameters and a small width helper.
// -----------------------------------------------------------------------------
package frame_seq_pkg;

    // Sequencer states
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_START  = 2'd1,
        ST_WAIT   = 2'd2,
        ST_COMMIT = 2'd3
    } seq_state_t;

    // VGA vertical timing (lines)
    localparam int LINE_W          = 10;
    localparam int VGA_VBLANK_LINE = 480;
    localparam int VGA_ACTIVE_LINE = 0;
    localparam int VGA_TOTAL_LINES = 525;

    // Sequencing defaults
    localparam int DEF_NUM_STAGES     = 4;
    localparam int DEF_TIMEOUT_CYCLES = 4096;

    // Bits needed to index n items; never less than one bit
    function automatic int idx_width(input int n);
        if (n > 1) begin
            return $clog2(n);
        end else begin
            return 1;
        end
    endfunction

endpackage : frame_seq_pkg

// File: rtl/line_event_detect.sv
// -----------------------------------------------------------------------------
// line_event_detect
// Registers the timing generator's line counter and flags the first cycle on
// which it reaches the blanking-start and active-start lines.
//
// Ports:
//   clock       in   pixel clock
//   reset       in   asynchronous, active-high reset
//   y           in   current line number
//   vblank_evt  out  y has just become VBLANK_LINE
//   active_evt  out  y has just become ACTIVE_LINE
// -----------------------------------------------------------------------------
module line_event_detect
    import frame_seq_pkg::*;
#(
    parameter int VBLANK_LINE = VGA_VBLANK_LINE,
    parameter int ACTIVE_LINE = VGA_ACTIVE_LINE
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [LINE_W-1:0] y,
    output logic              vblank_evt,
    output logic              active_evt
);

    logic [LINE_W-1:0] y_d_r;

    // Previous-cycle line value; resets to 0 so that y==0 right after reset
    // is not mistaken for the start of active video.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            y_d_r <= {LINE_W{1'b0}};
        end else begin
            y_d_r <= y;
        end
    end

    assign vblank_evt = (y == LINE_W'(VBLANK_LINE)) && (y_d_r != LINE_W'(VBLANK_LINE));
    assign active_evt = (y == LINE_W'(ACTIVE_LINE)) && (y_d_r != LINE_W'(ACTIVE_LINE));

endmodule : line_event_detect

// File: rtl/frame_update_sequencer.sv
// -----------------------------------------------------------------------------
// frame_update_sequencer
// On entry to vertical blanking, runs the game-logic update engines one at a
// time (start pulse, wait for done), then issues a single commit pulse so the
// render logic latches new object positions only during blanking. Active video
// starting mid-sequence aborts it (overrun); a stage that never answers aborts
// it after TIMEOUT_CYCLES (timeout).
//
// Ports:
//   clock         in   25 MHz pixel clock
//   reset         in   asynchronous, active-high reset
//   y             in   current line from timing generator
//   enable        in   arms sequencing for new frames
//   clear_status  in   clears sticky overrun/timeout flags
//   stage_done    in   per-stage done, only the active stage's bit is used
//   stage_start   out  one-hot, one-cycle start pulse to a stage
//   commit        out  one-cycle pulse after all stages finished
//   busy          out  sequencer is not idle
//   overrun       out  sticky: active video began before the sequence ended
//   timeout       out  sticky: a stage exceeded TIMEOUT_CYCLES
//   frame_count   out  committed frames, wraps 65535 -> 0
// -----------------------------------------------------------------------------
module frame_update_sequencer
    import frame_seq_pkg::*;
#(
    parameter int NUM_STAGES     = DEF_NUM_STAGES,
    parameter int VBLANK_LINE    = VGA_VBLANK_LINE,
    parameter int ACTIVE_LINE    = VGA_ACTIVE_LINE,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [LINE_W-1:0]     y,
    input  logic                  enable,
    input  logic                  clear_status,
    input  logic [NUM_STAGES-1:0] stage_done,
    output logic [NUM_STAGES-1:0] stage_start,
    output logic                  commit,
    output logic                  busy,
    output logic                  overrun,
    output logic                  timeout,
    output logic [15:0]           frame_count
);

    localparam int IDX_W = idx_width(NUM_STAGES);
    localparam int CNT_W = idx_width(TIMEOUT_CYCLES);

    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_STAGES - 1);
    localparam logic [CNT_W-1:0] LAST_WAIT = CNT_W'(TIMEOUT_CYCLES - 1);

    logic vblank_evt_s;
    logic active_evt_s;

    seq_state_t            state_r, state_n;
    logic [IDX_W-1:0]      idx_r, idx_n;
    logic [CNT_W-1:0]      cnt_r, cnt_n;
    logic                  overrun_r, overrun_n;
    logic                  timeout_r, timeout_n;
    logic [NUM_STAGES-1:0] stage_start_r, stage_start_n;
    logic                  commit_r;
    logic                  busy_r;
    logic [15:0]           frame_count_r;
    logic                  set_overrun_s;
    logic                  set_timeout_s;

    line_event_detect #(
        .VBLANK_LINE (VBLANK_LINE),
        .ACTIVE_LINE (ACTIVE_LINE)
    ) u_line_event_detect (
        .clock      (clock),
        .reset      (reset),
        .y          (y),
        .vblank_evt (vblank_evt_s),
        .active_evt (active_evt_s)
    );

    // Next-state, stage index, wait counter and sticky flag logic
    always_comb begin
        state_n       = state_r;
        idx_n         = idx_r;
        cnt_n         = cnt_r;
        set_overrun_s = 1'b0;
        set_timeout_s = 1'b0;

        case (state_r)
            ST_IDLE: begin
                if (vblank_evt_s && enable) begin
                    state_n = ST_START;
                    idx_n   = {IDX_W{1'b0}};
                end else begin
                    state_n = ST_IDLE;
                end
            end
            ST_START: begin
                state_n = ST_WAIT;
                cnt_n   = {CNT_W{1'b0}};
            end
            ST_WAIT: begin
                // done is checked before the timeout so a late-but-valid done wins
                if (stage_done[idx_r]) begin
                    if (idx_r == LAST_IDX) begin
                        state_n = ST_COMMIT;
                    end else begin
                        state_n = ST_START;
                        idx_n   = idx_r + IDX_W'(1);
                    end
                end else if (cnt_r == LAST_WAIT) begin
                    state_n       = ST_IDLE;
                    set_timeout_s = 1'b1;
                end else begin
                    cnt_n = cnt_r + CNT_W'(1);
                end
            end
            ST_COMMIT: begin
                state_n = ST_IDLE;
            end
            default: begin
                state_n = ST_IDLE;
            end
        endcase

        // Active video starting overrides every other transition
        if ((state_r != ST_IDLE) && active_evt_s) begin
            state_n       = ST_IDLE;
            set_overrun_s = 1'b1;
            set_timeout_s = 1'b0;
        end else begin
            set_overrun_s = 1'b0;
        end

        // A flag being set in the same cycle as clear_status stays set
        if (set_overrun_s) begin
            overrun_n = 1'b1;
        end else if (clear_status) begin
            overrun_n = 1'b0;
        end else begin
            overrun_n = overrun_r;
        end

        if (set_timeout_s) begin
            timeout_n = 1'b1;
        end else if (clear_status) begin
            timeout_n = 1'b0;
        end else begin
            timeout_n = timeout_r;
        end

        stage_start_n = {NUM_STAGES{1'b0}};
        if (state_n == ST_START) begin
            stage_start_n[idx_n] = 1'b1;
        end else begin
            stage_start_n = {NUM_STAGES{1'b0}};
        end
    end

    // State, counters, sticky flags and registered output decode
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_r       <= ST_IDLE;
            idx_r         <= {IDX_W{1'b0}};
            cnt_r         <= {CNT_W{1'b0}};
            overrun_r     <= 1'b0;
            timeout_r     <= 1'b0;
            stage_start_r <= {NUM_STAGES{1'b0}};
            commit_r      <= 1'b0;
            busy_r        <= 1'b0;
        end else begin
            state_r       <= state_n;
            idx_r         <= idx_n;
            cnt_r         <= cnt_n;
            overrun_r     <= overrun_n;
            timeout_r     <= timeout_n;
            stage_start_r <= stage_start_n;
            commit_r      <= (state_n == ST_COMMIT);
            busy_r        <= (state_n != ST_IDLE);
        end
    end

    // Committed-frame counter; increments as COMMIT is entered so the new
    // count is visible alongside the commit pulse
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            frame_count_r <= 16'd0;
        end else if (state_n == ST_COMMIT) begin
            frame_count_r <= frame_count_r + 16'd1;
        end
    end

    assign stage_start = stage_start_r;
    assign commit      = commit_r;
    assign busy        = busy_r;
    assign overrun     = overrun_r;
    assign timeout     = timeout_r;
    assign frame_count = frame_count_r;

endmodule : frame_update_sequencer
